vec_decode_seq: RTL and testbench

VEC_DECODE_SEQ -- requirements
Module: vec_decode_seq

---
 rtl/vec_decode_seq_if.sv | 21 ++
 rtl/vec_decode_seq.sv | 95 +++++++++
 tb/tb_vec_decode_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vec_decode_seq_if.sv
// vec_decode_seq_if: instruction-in / micro-op-out bus of the vector decode sequencer.
interface vec_decode_seq_if #(
    parameter int VL_W = 6
);
    logic [31:0]     instn_in;
    logic            instn_valid;
    logic            instn_ready;
    logic [VL_W-1:0] vlen;
    logic [31:0]     uop;
    logic            uop_valid;
    logic [4:0]      uop_elem;
    logic            uop_last;
    modport master(
        output instn_in, instn_valid, vlen,
        input  instn_ready, uop, uop_valid, uop_elem, uop_last
    );
    modport slave(
        input  instn_in, instn_valid, vlen,
        output instn_ready, uop, uop_valid, uop_elem, uop_last
    );
endinterface

// File: rtl/vec_decode_seq.sv
// vec_decode_seq: expands vector load/store instructions into per-element scalar micro-ops.
// Define VEC_DECODE_SEQ_DESC_EN for legacy descending element order (last micro-op is element 0).
module vec_decode_seq #(
    parameter int         NLANE   = 8,
    parameter int         VL_W    = 6,
    parameter logic [5:0] OP_LW_V = 6'h33,
    parameter logic [5:0] OP_SW_V = 6'h3B
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  busy,
    vec_decode_seq_if.slave       bus
);
    localparam int NW = $clog2(NLANE + 1);
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t          r_state, w_state;
    logic [31:0]     r_tmpl, w_tmpl, w_uop;
    logic [NW-1:0]   r_n, w_n, w_sat;
    logic [4:0]      w_elem, w_first, w_next;
    logic            w_valid, w_last, w_vec, w_accept, w_next_last;
    logic [31:0]     w_in_tmpl;
    assign w_vec     = bus.instn_in[31:26] == OP_LW_V || bus.instn_in[31:26] == OP_SW_V;
    assign w_sat     = (32'(bus.vlen) > 32'(NLANE)) ? NW'(NLANE) : NW'(bus.vlen);
    assign w_in_tmpl = {bus.instn_in[31], 1'b0, bus.instn_in[29:11], 5'd0, bus.instn_in[5:0]};
    assign bus.instn_ready = ~stall & ~flush & (r_state == IDLE | (r_state == EXPAND & bus.uop_last));
    assign w_accept  = bus.instn_valid & bus.instn_ready;
    assign busy      = r_state == EXPAND;
`ifdef VEC_DECODE_SEQ_DESC_EN
    assign w_first     = 5'(w_sat - NW'(1));
    assign w_next      = bus.uop_elem - 5'd1;
    assign w_next_last = w_next == 5'd0;
`else
    assign w_first     = 5'd0;
    assign w_next      = bus.uop_elem + 5'd1;
    assign w_next_last = w_next == 5'(r_n - NW'(1));
`endif
    always_comb begin
        w_state = r_state;
        w_tmpl  = r_tmpl;
        w_n     = r_n;
        w_uop   = bus.uop;
        w_valid = bus.uop_valid;
        w_elem  = bus.uop_elem;
        w_last  = bus.uop_last;
        if (flush) begin
            w_state = IDLE;
            w_valid = 1'b0;
        end else if (stall) begin
            w_state = r_state;
        end else if (w_accept && !w_vec) begin
            w_state = IDLE;
            w_uop   = bus.instn_in;
            w_valid = 1'b1;
            w_elem  = 5'd0;
            w_last  = 1'b1;
        end else if (w_accept) begin
            w_tmpl  = w_in_tmpl;
            w_n     = w_sat;
            w_valid = w_sat != '0;
            w_elem  = w_first;
            w_uop   = w_in_tmpl | {21'd0, w_first, 6'd0};
            w_last  = w_sat == NW'(1);
            w_state = (w_sat > NW'(1)) ? EXPAND : IDLE;
        end else if (r_state == EXPAND) begin
            w_valid = 1'b1;
            w_elem  = w_next;
            w_uop   = r_tmpl | {21'd0, w_next, 6'd0};
            w_last  = w_next_last;
            w_state = w_next_last ? IDLE : EXPAND;
        end else begin
            w_valid = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tmpl        <= '0;
            r_n           <= '0;
            bus.uop       <= '0;
            bus.uop_valid <= 1'b0;
            bus.uop_elem  <= '0;
            bus.uop_last  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_tmpl        <= w_tmpl;
            r_n           <= w_n;
            bus.uop       <= w_uop;
            bus.uop_valid <= w_valid;
            bus.uop_elem  <= w_elem;
            bus.uop_last  <= w_last;
        end
    end
endmodule

// File: tb/tb_vec_decode_seq.sv
// tb_vec_decode_seq: directed checks of scalar pass-through, vector expansion, stall, flush and reset.
module tb_vec_decode_seq;
    logic clk = 1'b0;
    logic rst_n, stall, flush, busy;
    int total = 0;
    int bad = 0;
    vec_decode_seq_if #(.VL_W(6)) bus();
    vec_decode_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic send(input logic [31:0] instn, input logic [5:0] vl);
        bus.instn_in    = instn;
        bus.vlen        = vl;
        bus.instn_valid = 1'b1;
        step();
        bus.instn_valid = 1'b0;
    endtask
    logic [31:0] exp_v4 [4] = '{32'h8C430820, 32'h8C430860, 32'h8C4308A0, 32'h8C4308E0};
    initial begin
        int cnt;
        logic [4:0] last_elem;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.instn_in = '0;
        bus.instn_valid = 1'b0;
        bus.vlen = '0;
        step();
        step();
        chk("rst_uop", bus.uop, 0);
        chk("rst_valid", 32'(bus.uop_valid), 0);
        chk("rst_elem", 32'(bus.uop_elem), 0);
        chk("rst_last", 32'(bus.uop_last), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();
        // scalar pass-through, then idle bubble
        bus.instn_in = 32'h8C220004;
        bus.instn_valid = 1'b1;
        #1 chk("sc_ready", 32'(bus.instn_ready), 1);
        step();
        bus.instn_valid = 1'b0;
        chk("sc_uop", bus.uop, 32'h8C220004);
        chk("sc_valid", 32'(bus.uop_valid), 1);
        chk("sc_last", 32'(bus.uop_last), 1);
        chk("sc_elem", 32'(bus.uop_elem), 0);
        chk("sc_busy", 32'(busy), 0);
        step();
        chk("idle_valid", 32'(bus.uop_valid), 0);
        // vlen=4 ascending; vlen changed mid-expansion must not matter
        send(32'hCC4308A0, 6'd4);
        bus.vlen = 6'd1;
        for (int k = 0; k < 4; k++) begin
            chk("v4_uop", bus.uop, exp_v4[k]);
            chk("v4_elem", 32'(bus.uop_elem), 32'(k));
            chk("v4_valid", 32'(bus.uop_valid), 1);
            chk("v4_last", 32'(bus.uop_last), 32'(k == 3));
            chk("v4_ready", 32'(bus.instn_ready), 32'(k == 3));
            if (k < 3) chk("v4_busy", 32'(busy), 1);
            step();
        end
        chk("v4_end_valid", 32'(bus.uop_valid), 0);
        // vlen=12 saturates to NLANE=8, store opcode
        send(32'hEC000000, 6'd12);
        cnt = 0;
        last_elem = '1;
        for (int c = 0; c < 12; c++) begin
            if (bus.uop_valid) cnt++;
            if (bus.uop_valid && bus.uop_elem == 5'd5) chk("v12_uop5", bus.uop, 32'hAC000140);
            if (bus.uop_valid && bus.uop_last) last_elem = bus.uop_elem;
            step();
        end
        chk("v12_count", 32'(cnt), 8);
        chk("v12_last_elem", 32'(last_elem), 7);
        // vlen=0 emits nothing
        send(32'hCC4308A0, 6'd0);
        chk("v0_valid", 32'(bus.uop_valid), 0);
        chk("v0_ready", 32'(bus.instn_ready), 1);
        chk("v0_busy", 32'(busy), 0);
        // stall 3 cycles at element 1
        send(32'hCC4308A0, 6'd4);
        step();
        chk("st_elem1", 32'(bus.uop_elem), 1);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("st_ready", 32'(bus.instn_ready), 0);
            step();
            chk("st_hold_elem", 32'(bus.uop_elem), 1);
            chk("st_hold_uop", bus.uop, 32'h8C430860);
        end
        stall = 1'b0;
        step();
        chk("st_elem2", 32'(bus.uop_elem), 2);
        step();
        chk("st_elem3", 32'(bus.uop_elem), 3);
        chk("st_last", 32'(bus.uop_last), 1);
        step();
        chk("st_end_valid", 32'(bus.uop_valid), 0);
        // flush at element 2 of vlen=8
        send(32'hCC4308A0, 6'd8);
        step();
        step();
        chk("fl_elem2", 32'(bus.uop_elem), 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(bus.uop_valid), 0);
        chk("fl_busy", 32'(busy), 0);
        send(32'h8C220004, 6'd0);
        chk("fl_next_uop", bus.uop, 32'h8C220004);
        chk("fl_next_valid", 32'(bus.uop_valid), 1);
        // vlen=2 followed back-to-back by a scalar
        send(32'hCC4308A0, 6'd2);
        step();
        chk("bb_last", 32'(bus.uop_last), 1);
        bus.instn_in = 32'h01234567;
        bus.instn_valid = 1'b1;
        #1 chk("bb_ready", 32'(bus.instn_ready), 1);
        step();
        bus.instn_valid = 1'b0;
        chk("bb_uop", bus.uop, 32'h01234567);
        chk("bb_valid", 32'(bus.uop_valid), 1);
        chk("bb_elem", 32'(bus.uop_elem), 0);
        // reset mid-vector abandons expansion
        send(32'hCC4308A0, 6'd4);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_uop", bus.uop, 0);
        chk("mr_valid", 32'(bus.uop_valid), 0);
        chk("mr_elem", 32'(bus.uop_elem), 0);
        chk("mr_last", 32'(bus.uop_last), 0);
        chk("mr_busy", 32'(busy), 0);
        step();
        chk("mr_after_valid", 32'(bus.uop_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
